// File: rtl/imem_pkg.sv
// Shared types, constants and the fetch-address fault rule for the
// synchronous instruction memory.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // MOV R0,R0: harmless filler fed to Decode whenever no real word exists.
  localparam logic [31:0] NOP_DEFAULT = 32'hE1A00000;

  // A fetch is bad if it is not word aligned or if any bit above the
  // word index is set; that second rule is what rules out aliasing.
  function automatic logic fetch_fault(input logic [31:0] addr,
                                       input int unsigned addr_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (addr_w + 2)) != 32'd0);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// 1R1W synchronous array: one write port for program load, one registered
// read port for fetch. The read register only updates when re is high.
module imem_ram
  import imem_pkg::*;
#(
  parameter int    ADDR_W    = 6,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Holding rdata_reg when re is low is what keeps the word steady in a stall.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with stall/flush, fetch fault
// detection and a valid/ready program-load port behind a LOAD/RUN FSM.
module imem_sync
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP       = DATA_W'(NOP_DEFAULT),
  parameter bit                BOOT_LOAD = 1'b1,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       a,
  input  logic              en,
  input  logic              flush,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              addr_fault,
  output logic              run,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last
);

  localparam state_t RESET_STATE = BOOT_LOAD ? LOAD : RUN;

  state_t            state_reg, state_next;
  logic              valid_reg, valid_next;
  logic              fault_reg, fault_next;
  logic              in_run;
  logic              fault_comb;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign in_run     = (state_reg == RUN);
  assign fault_comb = fetch_fault(a, ADDR_W);

  // A beat sampled while reset is held must not reach the array.
  assign ram_we = ld_ready & ld_valid & reset;
  assign ram_re = in_run & en & ~flush & ~fault_comb;

  imem_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (ram_re),
    .raddr (a[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RESET_STATE;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    fault_next = fault_reg;
    case (state_reg)
      LOAD: begin
        valid_next = 1'b0;
        fault_next = 1'b0;
        if (ld_valid && ld_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Leaving for LOAD and flushing both kill whatever was fetched.
        if (ld_start) begin
          state_next = LOAD;
          valid_next = 1'b0;
          fault_next = 1'b0;
        end else if (flush) begin
          valid_next = 1'b0;
          fault_next = 1'b0;
        end else if (en) begin
          valid_next = ~fault_comb;
          fault_next = fault_comb;
        end
      end
    endcase
  end

  // The array word is only exposed when it is a real fetch; every other
  // case (reset, LOAD, flush, fault) presents the NOP.
  assign rd         = valid_reg ? ram_rdata : NOP;
  assign rd_valid   = valid_reg;
  assign addr_fault = fault_reg;
  assign run        = in_run;
  assign ld_ready   = ~in_run;

endmodule
